// File: rtl/hazard_pkg.sv
// Shared definitions for the scoreboarded hazard unit: forward selects,
// pipeline control bundle and a constant-evaluable clog2.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE   = 6'b0000_00;
  localparam ctrl_t CTRL_FREEZE = 6'b1111_00;
  localparam ctrl_t CTRL_FLUSH  = 6'b0000_11;
  localparam ctrl_t CTRL_STALL  = 6'b1100_01;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Pipeline-side bundle of the hazard unit; master is the pipeline, slave is
// the hazard unit.
interface hazard_unit_sb_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_PEND   = 4,
  parameter int CNT_W      = 32
);

  localparam int NREGS = 2 ** REG_ADDR_W;
  localparam int PC_W  = clog2(MAX_PEND + 1);

  logic                  RegWriteM, RegWriteW;
  logic [REG_ADDR_W-1:0] RD_M, RD_W, RD_E, RD_D;
  logic [REG_ADDR_W-1:0] Rs1_E, Rs2_E, Rs1_D, Rs2_D;
  logic                  MemReadE, LongOpE, LongOpD, LongDoneW;
  logic [REG_ADDR_W-1:0] LongRD_W;
  logic                  PCSrcE, MemBusyM;
  logic [1:0]            ForwardAE, ForwardBE;
  logic                  StallF, StallD, StallE, StallM;
  logic                  FlushD, FlushE;
  logic [NREGS-1:0]      PendingVec;
  logic [PC_W-1:0]       PendCount;
  logic [CNT_W-1:0]      StallCycles;

  modport master (
    output RegWriteM, RegWriteW, RD_M, RD_W, RD_E, RD_D,
           Rs1_E, Rs2_E, Rs1_D, Rs2_D, MemReadE, LongOpE, LongOpD,
           LongDoneW, LongRD_W, PCSrcE, MemBusyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, PendingVec, PendCount, StallCycles
  );

  modport slave (
    input  RegWriteM, RegWriteW, RD_M, RD_W, RD_E, RD_D,
           Rs1_E, Rs2_E, Rs1_D, Rs2_D, MemReadE, LongOpE, LongOpD,
           LongDoneW, LongRD_W, PCSrcE, MemBusyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, PendingVec, PendCount, StallCycles
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending bits for in-flight long ops plus an in-flight count,
// with set/clear arbitration.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int REG_ADDR_W = 5,
  parameter  int MAX_PEND   = 4,
  localparam int NREGS      = 2 ** REG_ADDR_W,
  localparam int PC_W       = clog2(MAX_PEND + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  output logic [NREGS-1:0]      pending_vec,
  output logic [PC_W-1:0]       pend_count,
  output logic                  clr_valid
);

  localparam logic [NREGS-1:0]      ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
  localparam logic [PC_W-1:0]       CNT_MAX  = PC_W'(MAX_PEND);
  localparam logic [PC_W-1:0]       CNT_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

  logic [NREGS-1:0] pending_r;
  logic [NREGS-1:0] pending_nxt_s;
  logic [PC_W-1:0]  count_r;
  logic             clr_valid_s, set_ok_s, same_s, inc_s, dec_s;

  // Set/clear arbitration: a same-register set and clear leaves the bit set and the count unchanged.
  always_comb begin
    clr_valid_s   = clr_en & pending_r[clr_addr];
    set_ok_s      = set_en & (set_addr != REG_ZERO);
    same_s        = set_ok_s & clr_valid_s & (set_addr == clr_addr);
    dec_s         = clr_valid_s & ~same_s;
    inc_s         = set_ok_s & ~pending_r[set_addr] & ((count_r != CNT_MAX) | dec_s);
    pending_nxt_s = (pending_r & ~(dec_s ? (ONE_HOT0 << clr_addr) : {NREGS{1'b0}}))
                  | (inc_s ? (ONE_HOT0 << set_addr) : {NREGS{1'b0}});
  end

  // Pending vector and in-flight count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {NREGS{1'b0}};
      count_r   <= {PC_W{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
      case ({inc_s, dec_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign pending_vec = pending_r;
  assign pend_count  = count_r;
  assign clr_valid   = clr_valid_s;

endmodule

// File: rtl/hazard_unit_sb.sv
// Scoreboarded hazard unit: EX operand forwarding, load-use / long-op /
// occupancy stalls, branch flush, memory-wait freeze and a stall counter.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_PEND   = 4,
  parameter int CNT_W      = 32
) (
  input logic             clk,
  input logic             rst,
  hazard_unit_sb_if.slave hz
);

  localparam int NREGS = 2 ** REG_ADDR_W;
  localparam int PC_W  = clog2(MAX_PEND + 1);
  localparam logic [NREGS-1:0]      ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
  localparam logic [PC_W-1:0]       CNT_MAX  = PC_W'(MAX_PEND);
  localparam logic [CNT_W-1:0]      SC_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NREGS-1:0] pending_s, visible_s;
  logic [PC_W-1:0]  pend_count_s;
  logic             clr_valid_s, set_en_s;
  logic             lu_s, sb_s, full_s;
  logic [1:0]       fwd_a_s, fwd_b_s;
  ctrl_t            ctrl_s;
  logic [CNT_W-1:0] stall_cycles_r;

  hazard_scoreboard #(
    .REG_ADDR_W(REG_ADDR_W),
    .MAX_PEND  (MAX_PEND)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en     (set_en_s),
    .set_addr   (hz.RD_E),
    .clr_en     (hz.LongDoneW),
    .clr_addr   (hz.LongRD_W),
    .pending_vec(pending_s),
    .pend_count (pend_count_s),
    .clr_valid  (clr_valid_s)
  );

  // Operand forwarding: MEM beats WB, x0 and non-writing stages never forward.
  always_comb begin
    fwd_a_s = FWD_NONE;
    fwd_b_s = FWD_NONE;
    if (rst) begin
      fwd_a_s = FWD_NONE;
      fwd_b_s = FWD_NONE;
    end else begin
      if (hz.RegWriteM && hz.RD_M != REG_ZERO && hz.RD_M == hz.Rs1_E) fwd_a_s = FWD_MEM;
      else if (hz.RegWriteW && hz.RD_W != REG_ZERO && hz.RD_W == hz.Rs1_E) fwd_a_s = FWD_WB;
      else fwd_a_s = FWD_NONE;
      if (hz.RegWriteM && hz.RD_M != REG_ZERO && hz.RD_M == hz.Rs2_E) fwd_b_s = FWD_MEM;
      else if (hz.RegWriteW && hz.RD_W != REG_ZERO && hz.RD_W == hz.Rs2_E) fwd_b_s = FWD_WB;
      else fwd_b_s = FWD_NONE;
    end
  end

  // Hazard detection and stall/flush priority; a result written back this cycle is already readable in ID.
  always_comb begin
    visible_s = pending_s & ~(hz.LongDoneW ? (ONE_HOT0 << hz.LongRD_W) : {NREGS{1'b0}});
    lu_s   = hz.MemReadE & (hz.RD_E != REG_ZERO)
           & ((hz.RD_E == hz.Rs1_D) | (hz.RD_E == hz.Rs2_D));
    sb_s   = ((hz.Rs1_D != REG_ZERO) & visible_s[hz.Rs1_D])
           | ((hz.Rs2_D != REG_ZERO) & visible_s[hz.Rs2_D])
           | ((hz.RD_D  != REG_ZERO) & visible_s[hz.RD_D]);
    full_s = hz.LongOpD & (pend_count_s == CNT_MAX) & ~clr_valid_s;
    if (rst)                        ctrl_s = CTRL_IDLE;
    else if (hz.MemBusyM)           ctrl_s = CTRL_FREEZE;
    else if (hz.PCSrcE)             ctrl_s = CTRL_FLUSH;
    else if (lu_s | sb_s | full_s)  ctrl_s = CTRL_STALL;
    else                            ctrl_s = CTRL_IDLE;
    set_en_s = hz.LongOpE & ~ctrl_s.stall_e & ~ctrl_s.flush_e;
  end

  // Saturating count of cycles spent with ID held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_r <= {CNT_W{1'b0}};
    end else if (ctrl_s.stall_d && stall_cycles_r != {CNT_W{1'b1}}) begin
      stall_cycles_r <= stall_cycles_r + SC_ONE;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign hz.ForwardAE   = fwd_a_s;
  assign hz.ForwardBE   = fwd_b_s;
  assign hz.StallF      = ctrl_s.stall_f;
  assign hz.StallD      = ctrl_s.stall_d;
  assign hz.StallE      = ctrl_s.stall_e;
  assign hz.StallM      = ctrl_s.stall_m;
  assign hz.FlushD      = ctrl_s.flush_d;
  assign hz.FlushE      = ctrl_s.flush_e;
  assign hz.PendingVec  = pending_s;
  assign hz.PendCount   = pend_count_s;
  assign hz.StallCycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed-vector bench for hazard_unit_sb (MAX_PEND=2, 4-bit stall counter);
// expected responses are queued by the driver and checked by a monitor.
module tb_hazard_unit_sb;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [3:0]  st;
    logic [1:0]  fl;
    logic [1:0]  pc;
    logic [31:0] pv;
    logic [3:0]  sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk = 1'b0;
  exp_t exp_q[$];
  exp_t act_m, exp_m;
  int   n_vec  = 0;
  int   n_fail = 0;

  hazard_unit_sb_if #(.REG_ADDR_W(5), .MAX_PEND(2), .CNT_W(4)) hz ();

  hazard_unit_sb #(.REG_ADDR_W(5), .MAX_PEND(2), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                              input logic [3:0] st, input logic [1:0] fl,
                              input logic [1:0] pc, input logic [31:0] pv,
                              input logic [3:0] sc);
    exp_t e;
    e = '{fa, fb, st, fl, pc, pv, sc};
    return e;
  endfunction

  function automatic logic [31:0] bit_of(input int r);
    return 32'd1 << r;
  endfunction

  task automatic idle();
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.RD_M = 5'd0; hz.RD_W = 5'd0; hz.RD_E = 5'd0; hz.RD_D = 5'd0;
    hz.Rs1_E = 5'd0; hz.Rs2_E = 5'd0; hz.Rs1_D = 5'd0; hz.Rs2_D = 5'd0;
    hz.MemReadE = 1'b0; hz.LongOpE = 1'b0; hz.LongOpD = 1'b0;
    hz.LongDoneW = 1'b0; hz.LongRD_W = 5'd0;
    hz.PCSrcE = 1'b0; hz.MemBusyM = 1'b0;
  endtask

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    chk = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every checked cycle the DUT presents a response at the falling edge.
  always @(negedge clk) begin
    if (chk) begin
      act_m = '{hz.ForwardAE, hz.ForwardBE,
                {hz.StallF, hz.StallD, hz.StallE, hz.StallM},
                {hz.FlushD, hz.FlushE}, hz.PendCount, hz.PendingVec, hz.StallCycles};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL vec%0d: response with no queued expectation", n_vec);
      end else begin
        exp_m = exp_q.pop_front();
        if (act_m !== exp_m) begin
          n_fail++;
          $display("FAIL vec%0d: got fwd=%b/%b stall=%b flush=%b pcnt=%0d pvec=%h scyc=%0d, want fwd=%b/%b stall=%b flush=%b pcnt=%0d pvec=%h scyc=%0d",
                   n_vec, act_m.fa, act_m.fb, act_m.st, act_m.fl, act_m.pc, act_m.pv, act_m.sc,
                   exp_m.fa, exp_m.fb, exp_m.st, exp_m.fl, exp_m.pc, exp_m.pv, exp_m.sc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;

    // reset gates everything even with hazards present
    hz.MemBusyM = 1'b1; hz.RegWriteM = 1'b1; hz.RD_M = 5'd5; hz.Rs1_E = 5'd5;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd0));
    rst = 1'b0; idle();
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd0));

    // forwarding
    idle(); hz.RegWriteM = 1'b1; hz.RD_M = 5'd5; hz.RegWriteW = 1'b1; hz.RD_W = 5'd5;
    hz.Rs1_E = 5'd5; hz.Rs2_E = 5'd6;
    step(mk(2'b10, 2'b00, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd0));
    hz.RD_M = 5'd0; hz.Rs2_E = 5'd5;
    step(mk(2'b01, 2'b01, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd0));
    idle(); hz.RD_M = 5'd5; hz.RegWriteW = 1'b1; hz.RD_W = 5'd0; hz.Rs1_E = 5'd5; hz.Rs2_E = 5'd0;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd0));

    // load-use, then with branch, then load to x0
    idle(); hz.MemReadE = 1'b1; hz.RD_E = 5'd7; hz.Rs2_D = 5'd7;
    step(mk(2'b00, 2'b00, 4'b1100, 2'b01, 2'd0, 32'd0, 4'd0));
    idle();
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd1));
    hz.MemReadE = 1'b1; hz.RD_E = 5'd7; hz.Rs2_D = 5'd7; hz.PCSrcE = 1'b1;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b11, 2'd0, 32'd0, 4'd1));
    idle(); hz.MemReadE = 1'b1; hz.RD_E = 5'd0; hz.Rs1_D = 5'd0;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd1));

    // memory freeze beats branch; branch flush after release
    idle(); hz.MemBusyM = 1'b1; hz.PCSrcE = 1'b1;
    step(mk(2'b00, 2'b00, 4'b1111, 2'b00, 2'd0, 32'd0, 4'd1));
    hz.MemBusyM = 1'b0;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b11, 2'd0, 32'd0, 4'd2));

    // DIV x9 issues, dependent waits 9 cycles, leaves ID in the done cycle
    idle(); hz.LongOpE = 1'b1; hz.RD_E = 5'd9;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd2));
    for (int k = 1; k <= 9; k++) begin
      idle(); hz.Rs1_D = 5'd9;
      step(mk(2'b00, 2'b00, 4'b1100, 2'b01, 2'd1, bit_of(9), 4'(k + 1)));
    end
    idle(); hz.Rs1_D = 5'd9; hz.LongDoneW = 1'b1; hz.LongRD_W = 5'd9;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd1, bit_of(9), 4'd11));
    idle();
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd11));

    // occupancy limit: x3, x4 in flight, third long op waits for a completion
    idle(); hz.LongOpE = 1'b1; hz.RD_E = 5'd3;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd11));
    idle(); hz.LongOpE = 1'b1; hz.RD_E = 5'd4;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd1, bit_of(3), 4'd11));
    idle(); hz.LongOpD = 1'b1; hz.RD_D = 5'd5;
    step(mk(2'b00, 2'b00, 4'b1100, 2'b01, 2'd2, bit_of(3) | bit_of(4), 4'd11));
    hz.LongDoneW = 1'b1; hz.LongRD_W = 5'd3;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd2, bit_of(3) | bit_of(4), 4'd12));
    idle();
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd1, bit_of(4), 4'd12));

    // stall counter saturation at 15
    for (int k = 0; k < 5; k++) begin
      idle(); hz.MemReadE = 1'b1; hz.RD_E = 5'd7; hz.Rs1_D = 5'd7;
      step(mk(2'b00, 2'b00, 4'b1100, 2'b01, 2'd1, bit_of(4), (k < 3) ? 4'(12 + k) : 4'd15));
    end
    idle();
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd1, bit_of(4), 4'd15));

    // same-register set+clear, stray clear, x0 issue, issue under freeze
    idle(); hz.LongOpE = 1'b1; hz.RD_E = 5'd4; hz.LongDoneW = 1'b1; hz.LongRD_W = 5'd4;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd1, bit_of(4), 4'd15));
    idle(); hz.LongDoneW = 1'b1; hz.LongRD_W = 5'd8;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd1, bit_of(4), 4'd15));
    idle(); hz.LongOpE = 1'b1; hz.RD_E = 5'd0;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd1, bit_of(4), 4'd15));
    idle(); hz.LongOpE = 1'b1; hz.RD_E = 5'd6; hz.MemBusyM = 1'b1;
    step(mk(2'b00, 2'b00, 4'b1111, 2'b00, 2'd1, bit_of(4), 4'd15));

    // WAW on pending destination, then bypassed by the completing write
    idle(); hz.RD_D = 5'd4;
    step(mk(2'b00, 2'b00, 4'b1100, 2'b01, 2'd1, bit_of(4), 4'd15));
    hz.LongDoneW = 1'b1; hz.LongRD_W = 5'd4;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd1, bit_of(4), 4'd15));

    // mid-operation reset drops pending x3; its later completion is ignored
    idle(); hz.LongOpE = 1'b1; hz.RD_E = 5'd3;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd15));
    rst = 1'b1; idle(); hz.MemBusyM = 1'b1; hz.PCSrcE = 1'b1;
    hz.RegWriteM = 1'b1; hz.RD_M = 5'd5; hz.Rs1_E = 5'd5;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd1, bit_of(3), 4'd15));
    rst = 1'b0; idle(); hz.LongDoneW = 1'b1; hz.LongRD_W = 5'd3;
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd0));
    idle();
    step(mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 32'd0, 4'd0));
    chk = 1'b0;

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations never matched by a response, want 0", exp_q.size());
      n_fail = n_fail + exp_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
